// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART TX arbiter slice.
//   arb_state_t       : arbiter FSM states
//   SRC_KEY / SRC_RX  : source identifiers carried on tx_src
//   ASCII_*_BASE      : offsets used by the optional keypad-to-ASCII mapping
//   tmo_cnt_width()   : width of the start-timeout counter
//   key_to_ascii()    : hex key code to ASCII character
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE
    } arb_state_t;

    localparam logic SRC_KEY = 1'b0;
    localparam logic SRC_RX  = 1'b1;

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    // 0x37 + 0xA = 0x41 ('A'), so letters need no separate subtraction.
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

    function automatic int tmo_cnt_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic logic [7:0] key_to_ascii(input logic [3:0] code);
        if (code < 4'd10) begin
            return ASCII_DIGIT_BASE + {4'h0, code};
        end
        return ASCII_ALPHA_BASE + {4'h0, code};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word fall-through FIFO. dout shows the oldest entry
// whenever empty is low; pop consumes it.
// Ports:
//   pllclk, nRST : clock, asynchronous active-low reset (pointers/count only)
//   push, din    : write request and data; ignored when full unless popping
//   pop          : consume head entry; ignored when empty
//   dout         : head entry
//   full, empty  : occupancy status
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             pllclk,
    input  logic             nRST,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        // A full FIFO still accepts a write when the head leaves this cycle.
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
    end

    always_ff @(posedge pllclk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge pllclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between keypad events and RX echo bytes.
// Each request level is synchronised into pllclk, edge-detected, and queued
// in a per-source FIFO. An FSM pops the granted FIFO and drives the
// transmitter with a level start/busy handshake.
// Ports:
//   pllclk, nRST          : 100 MHz clock, asynchronous active-low reset
//   key_valid, key_value  : keypad event level and 4-bit hex code
//   rx_valid, rx_data     : RX byte-valid level and byte to echo
//   tx_busy               : transmitter busy (slow domain)
//   tx_start, tx_data     : start request (held until busy seen) and byte
//   tx_src                : source of current/last byte (0 key, 1 rx)
//   key_ovf, rx_ovf       : sticky FIFO-overflow flags
//   tx_timeout            : sticky start-timeout flag
//   idle                  : FSM idle, both FIFOs empty, busy low
// Build option: define KEY_ASCII_EN to queue keypad codes as ASCII
// characters instead of {4'h0, key_value}.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ROUND_ROBIN   = 1,
    parameter int START_TIMEOUT = 1023
) (
    input  logic       pllclk,
    input  logic       nRST,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       tx_src,
    output logic       key_ovf,
    output logic       rx_ovf,
    output logic       tx_timeout,
    output logic       idle
);

    localparam int TMO_W = tmo_cnt_width(START_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);

    // Synchroniser bit order: {busy, rx, key}
    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;
    logic [1:0] prev_q, prev_d;

    logic       busy_s;
    logic       key_push, rx_push;
    logic [7:0] key_byte;

    logic       key_pop, rx_pop;
    logic [7:0] key_dout, rx_dout;
    logic       key_full, key_empty, rx_full, rx_empty;
    logic       grant_rx;

    arb_state_t       state_q, state_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_src_q, tx_src_d;
    logic             last_src_q, last_src_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tx_timeout_q, tx_timeout_d;
    logic             key_ovf_q, key_ovf_d;
    logic             rx_ovf_q, rx_ovf_d;

    // ---------------- input capture ----------------
    always_comb begin
        meta_d   = {tx_busy, rx_valid, key_valid};
        sync_d   = meta_q;
        prev_d   = sync_q[1:0];
        busy_s   = sync_q[2];
        // One push per assertion: only the synchronised rising edge writes.
        key_push = sync_q[0] & ~prev_q[0];
        rx_push  = sync_q[1] & ~prev_q[1];
    end

    always_comb begin
`ifdef KEY_ASCII_EN
        key_byte = key_to_ascii(key_value);
`else
        key_byte = {4'h0, key_value};
`endif
    end

    // ---------------- per-source buffering ----------------
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .pllclk (pllclk),
        .nRST   (nRST),
        .push   (key_push),
        .din    (key_byte),
        .pop    (key_pop),
        .dout   (key_dout),
        .full   (key_full),
        .empty  (key_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .pllclk (pllclk),
        .nRST   (nRST),
        .push   (rx_push),
        .din    (rx_data),
        .pop    (rx_pop),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    // ---------------- arbitration and handshake ----------------
    always_comb begin
        grant_rx = 1'b0;
        if (key_empty && !rx_empty) begin
            grant_rx = 1'b1;
        end else if (!key_empty && !rx_empty) begin
            grant_rx = (ROUND_ROBIN != 0) && (last_src_q == SRC_KEY);
        end
    end

    always_comb begin
        state_d      = state_q;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        tx_src_d     = tx_src_q;
        last_src_d   = last_src_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_timeout_d = tx_timeout_q;
        key_pop      = 1'b0;
        rx_pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A transmitter still busy (e.g. after a local reset) blocks launch.
                if (!busy_s && (!key_empty || !rx_empty)) begin
                    if (grant_rx) begin
                        rx_pop    = 1'b1;
                        tx_data_d = rx_dout;
                        tx_src_d  = SRC_RX;
                    end else begin
                        key_pop   = 1'b1;
                        tx_data_d = key_dout;
                        tx_src_d  = SRC_KEY;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_start_d = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = START;
            end
            START: begin
                if (busy_s) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Transmitter never answered: abandon this byte.
                    tx_start_d   = 1'b0;
                    tx_timeout_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    last_src_d = tx_src_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Drop only when the write cannot ride on a same-cycle pop.
        key_ovf_d = key_ovf_q | (key_push & key_full & ~key_pop);
        rx_ovf_d  = rx_ovf_q  | (rx_push  & rx_full  & ~rx_pop);
    end

    always_ff @(posedge pllclk or negedge nRST) begin
        if (!nRST) begin
            meta_q       <= '0;
            sync_q       <= '0;
            prev_q       <= '0;
            state_q      <= IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_src_q     <= SRC_KEY;
            last_src_q   <= SRC_RX;
            tmo_cnt_q    <= '0;
            tx_timeout_q <= 1'b0;
            key_ovf_q    <= 1'b0;
            rx_ovf_q     <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            tx_src_q     <= tx_src_d;
            last_src_q   <= last_src_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_timeout_q <= tx_timeout_d;
            key_ovf_q    <= key_ovf_d;
            rx_ovf_q     <= rx_ovf_d;
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign tx_src     = tx_src_q;
    assign key_ovf    = key_ovf_q;
    assign rx_ovf     = rx_ovf_q;
    assign tx_timeout = tx_timeout_q;
    assign idle       = (state_q == IDLE) & key_empty & rx_empty & ~busy_s;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two requesters: keypad key events and UART RX echo bytes.
- Synchronises each request into the pllclk domain and buffers it per source.
- Arbitrates between the sources and drives the transmitter with a level start/busy handshake, so a slow-clocked transmitter never misses a start.
- Sits between hex_keypad/uart_rx and uart_tx in the top level, replacing the ad-hoc TX trigger logic.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2
ROUND_ROBIN, 1, 1 = alternate sources when both are pending; 0 = keypad has fixed priority
START_TIMEOUT, 1023, pllclk cycles to wait for tx_busy to rise after tx_start before aborting

Ports:
pllclk  in  1  system clock (100 MHz PLL output)
nRST  in  1  asynchronous, active-low reset
key_valid  in  1  keypad event level (slow domain); key_value stable while high
key_value  in  4  hex key code
rx_valid  in  1  RX byte-valid level (slow domain); rx_data stable while high
rx_data  in  8  received byte to echo
tx_busy  in  1  transmitter busy (slow domain)
tx_start  out  1  start request, held until tx_busy is seen high
tx_data  out  8  byte to transmit, stable from tx_start rise until busy falls
tx_src  out  1  source of the current or last byte: 0 = key, 1 = rx
key_ovf  out  1  sticky: a keypad event was dropped because its FIFO was full
rx_ovf  out  1  sticky: an RX byte was dropped because its FIFO was full
tx_timeout  out  1  sticky: a start request timed out
idle  out  1  state is IDLE, both FIFOs are empty and busy_s is low

Behaviour:
- Reset (async, nRST low):
  - Outputs: tx_start=0, tx_data=0x00, tx_src=0, all sticky flags 0.
  - Both FIFOs empty, state IDLE, last_src=1 so the keypad wins the first tie.
  - Synchroniser flops cleared.
- Input capture:
  - key_valid, rx_valid and tx_busy each pass through a 2-flop synchroniser; the synchronised busy signal is busy_s.
  - A FIFO write occurs on the rising edge of the synchronised valid, detected with a third flop.
  - Data is captured on the same cycle as the write.
  - One write per valid assertion, whatever its high time.
- FIFOs:
  - Push to a full FIFO: data dropped, the matching ovf flag set; ovf flags clear only on reset.
  - Push and pop in the same cycle on a full FIFO: both succeed and the count is unchanged.
  - Keypad and RX pushes in the same cycle are both accepted into their own FIFOs.
- FSM states: IDLE, LOAD, START, WAIT_DONE.
  - IDLE: if busy_s=0 and any FIFO is non-empty, pop the granted FIFO, register tx_data and tx_src, go to LOAD.
  - IDLE with busy_s=1 (e.g. transmitter still mid-frame after a local reset): no launch.
  - LOAD: assert tx_start, clear the timeout counter, go to START.
  - START: hold tx_start=1. When busy_s=1, drop tx_start and go to WAIT_DONE. If the counter reaches START_TIMEOUT, drop tx_start, set tx_timeout, return to IDLE; the byte is lost.
  - WAIT_DONE: when busy_s=0, update last_src and go to IDLE.
- Grant:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty, ROUND_ROBIN=1: grant the source different from last_src.
  - Both non-empty, ROUND_ROBIN=0: keypad always granted.
- Latency: with both FIFOs empty and busy_s=0, tx_start rises after the 5th pllclk edge, counting the edge that first samples the valid high as edge 1.
- tx_data changes only in IDLE on a pop.

Optional Feature:
- Macro: KEY_ASCII_EN.
- Defined: keypad code converted to ASCII before FIFO write.
  - 0-9 -> 0x30-0x39.
  - A-F -> 0x41-0x46.
- Undefined: keypad byte is {4'h0, key_value}.
- RX path is unaffected in both cases.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (IDLE/LOAD/START/WAIT_DONE)
  - SRC_KEY=0, SRC_RX=1
  - ASCII_DIGIT_BASE=0x30, ASCII_ALPHA_BASE=0x37
  - timeout counter width derived from START_TIMEOUT
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/dout, first-word fall-through), instantiated twice.
- Synchronisers and edge detect stay inline.

Test Plan:
- key_value=0xA held 200 ns, transmitter model asserts busy 40 cycles after start for 1000 cycles -> exactly one byte 0x41 (0x0A with macro off), tx_src=0; tx_start rises after edge 5, falls 2 cycles after busy rises.
- Keypad 0x3 and rx_data=0x55 pulsed in the same cycle, ROUND_ROBIN=1 -> bytes sent in the order 0x33 then 0x55; with ROUND_ROBIN=0 and 3 keys plus 1 rx queued -> all 3 keys sent before 0x55.
- 6 RX bytes 0x01..0x06 while busy held high, FIFO_DEPTH=4 -> 0x01..0x04 transmitted, rx_ovf=1, key_ovf=0.
- tx_busy tied low, one key event -> tx_start high for START_TIMEOUT cycles, then tx_timeout=1, idle=1, next key event still launched.
- nRST pulsed low during WAIT_DONE with tx_busy held high -> tx_start=0 immediately, FIFOs empty, and no launch until busy_s falls even with a new pending key.
- 100 consecutive alternating key/rx events with random busy lengths -> every accepted byte appears exactly once, per-source order preserved, tx_data stable during each start/busy window.
